// File: rtl/bsreg_feeder.sv
// bsreg_feeder: valid/ready word serializer for a bidirectional shift register; BSREG_FEEDER_PARITY_EN appends an even-parity bit
module bsreg_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             serial_out,
  output logic             dir_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0] cnt;
  logic nxt;
  assign load_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef BSREG_FEEDER_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  logic par;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (state == IDLE && load_valid) par <= ^load_data;
  assign nxt = cnt == CW'(WIDTH - 1) ? par : dir_out ? hold[WIDTH-1] : hold[0];
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  assign nxt = dir_out ? hold[WIDTH-1] : hold[0];
`endif
  // hold always keeps the not-yet-presented bits at the end nearest the exit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      serial_out <= 1'b0;
      dir_out <= 1'b0;
      shift_en <= 1'b0;
      cnt <= '0;
      hold <= '0;
    end else if (state == IDLE) begin
      if (load_valid) begin
        state <= SHIFT;
        shift_en <= 1'b1;
        dir_out <= load_dir;
        serial_out <= load_dir ? load_data[WIDTH-1] : load_data[0];
        hold <= load_dir ? load_data << 1 : load_data >> 1;
        cnt <= '0;
      end
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state <= DONE;
        shift_en <= 1'b0;
        serial_out <= 1'b0;
      end else begin
        serial_out <= nxt;
        hold <= dir_out ? hold << 1 : hold >> 1;
        cnt <= cnt + 1'b1;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bsreg_feeder.sv
// tb_bsreg_feeder: random and directed stimulus against a queue-based cycle model of bsreg_feeder
module tb_bsreg_feeder;
  localparam int W = 4;
`ifdef BSREG_FEEDER_PARITY_EN
  localparam int NS = W + 1;
`else
  localparam int NS = W;
`endif
  typedef logic [5:0] ev_t;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, load_dir = 1'b0;
  logic [W-1:0] load_data = '0;
  logic load_ready, serial_out, dir_out, shift_en, busy, done;
  bsreg_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dir(load_dir), .serial_out(serial_out),
    .dir_out(dir_out), .shift_en(shift_en), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  ev_t q[$];
  logic ldir = 1'b0;
  int cyc_n = 0, n_se = 0, n_done = 0, n_acc = 0, t_acc = 0, t_done = 0;
  logic [7:0] sent = '0;
  logic [W-1:0] ds = '0;
  // expected per-cycle outputs {ready,busy,done,shift_en,serial,dir} after each edge
  always @(posedge clk) begin
    cyc_n++;
    if (shift_en) begin
      sent = {sent[6:0], serial_out};
      n_se++;
      ds = dir_out ? {ds[W-2:0], serial_out} : {serial_out, ds[W-1:1]};
    end
    if (done) begin
      n_done++;
      t_done = cyc_n;
    end
    if (rst) begin
      q.delete();
      ldir = 1'b0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (load_valid) begin
      ldir = load_dir;
      n_acc++;
      t_acc = cyc_n;
      for (int i = 0; i < W; i++)
        q.push_back({4'b0101, load_dir ? load_data[W-1-i] : load_data[i], load_dir});
`ifdef BSREG_FEEDER_PARITY_EN
      q.push_back({4'b0101, ^load_data, load_dir});
`endif
      q.push_back({5'b01100, load_dir});
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic compare_loop();
    ev_t e;
    forever begin
      @(negedge clk);
      e = q.size() > 0 ? q[0] : {5'b10000, ldir};
      chk("cycle", {26'd0, load_ready, busy, done, shift_en, serial_out, dir_out}, {26'd0, e});
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input logic dr);
    int n;
    n = 0;
    while (!load_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", n < 40, 1);
    load_valid = 1'b1;
    load_data = d;
    load_dir = dr;
    tick();
    load_valid = 1'b0;
  endtask
  task automatic word(input string name, input logic [W-1:0] d, input logic dr,
                      input logic [W-1:0] exp_bits, input logic [W-1:0] exp_ds);
    int s0, d0;
    logic [W-1:0] db;
    s0 = n_se;
    d0 = n_done;
    send(d, dr);
    repeat (NS + 2) tick();
    db = W'(sent >> (NS - W));
    chk({name, "_shifts"}, n_se - s0, NS);
    chk({name, "_done_cnt"}, n_done - d0, 1);
    chk({name, "_done_time"}, t_done - t_acc, NS + 1);
    chk({name, "_bits"}, db, exp_bits);
`ifndef BSREG_FEEDER_PARITY_EN
    chk({name, "_downstream"}, ds, exp_ds);
`endif
  endtask
  initial begin
    int a0, a1, n, d0;
    fork
      compare_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", load_ready, 1);
    chk("reset_outs", {busy, done, shift_en, serial_out, dir_out}, 0);
    word("t2", 4'b1011, 1'b0, 4'b1101, 4'b1011);
    word("t3", 4'b1000, 1'b1, 4'b1000, 4'b1000);
    load_valid = 1'b1;
    load_data = 4'hA;
    load_dir = 1'b0;
    a0 = n_acc;
    n = 0;
    while (n_acc == a0 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_acc1", n_acc, a0 + 1);
    a1 = t_acc;
    load_data = 4'h5;
    n = 0;
    while (n_acc == a0 + 1 && n < 40) begin
      tick();
      n++;
    end
    load_valid = 1'b0;
    chk("t4_acc2", n_acc, a0 + 2);
    chk("t4_interval", t_acc - a1, NS + 2);
    repeat (NS + 2) tick();
    chk("t4_bits", W'(sent >> (NS - W)), 4'b1010);
    d0 = n_done;
    send(4'hF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_abort", {load_ready, busy, done, shift_en}, 4'b1000);
    repeat (3) tick();
    chk("t5_nodone", n_done - d0, 0);
    word("t5_next", 4'h3, 1'b0, 4'b1100, 4'h3);
`ifdef BSREG_FEEDER_PARITY_EN
    word("t6", 4'b0111, 1'b0, 4'b1110, 4'b0);
    chk("t6_parity_bits", sent[4:0], 5'b11101);
    chk("t6_done_time", t_done - t_acc, 6);
`endif
    for (int i = 0; i < 500; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data = W'($urandom);
      load_dir = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 59) == 0;
      tick();
    end
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (NS + 4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
